// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word accesses with sign or zero extension.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two memory beats; otherwise they are flagged as errors.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_memWrEnable,
  input  logic [4:0]  i_mask,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [29:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif

  state_t             r_state;
  logic [31:0]        r_addr;
  logic [4:0]         r_mask;
  logic               r_we;
  logic [4*SPAN-1:0]  r_be;
  logic [32*SPAN-1:0] r_wd;
  logic [31:0]        r_rd_lo;
  logic [31:0]        r_rd_hi;
  logic [31:0]        r_ld_data;
  logic               r_err;

  logic [1:0]         w_off;
  logic               w_size_ok;
  logic               w_bad;
  logic [4*SPAN-1:0]  w_be;
  logic [32*SPAN-1:0] w_wd;
  logic [31:0]        w_ext;

  function automatic logic [31:0] extend(input logic [63:0] rd, input logic [1:0] off,
                                         input logic [4:0] m);
    logic [31:0] sh;
    sh = rd[{off, 3'b000} +: 32];
    case (m[3:0])
      4'b0001: extend = {{24{~m[4] & sh[7]}}, sh[7:0]};
      4'b0011: extend = {{16{~m[4] & sh[15]}}, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  assign w_off     = i_addr[1:0];
  assign w_size_ok = (i_mask[3:0] == 4'b0001) || (i_mask[3:0] == 4'b0011) ||
                     (i_mask[3:0] == 4'b1111);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic w_hi;
  assign w_be        = {4'b0000, i_mask[3:0]} << w_off;
  assign w_wd        = {32'h0, i_st_data} << {w_off, 3'b000};
  assign w_bad       = !w_size_ok;
  assign w_hi        = (r_state == ACC2);
  assign o_mem_addr  = r_addr[31:2] + {29'b0, w_hi};
  assign o_mem_be    = w_hi ? r_be[7:4] : r_be[3:0];
  assign o_mem_wdata = w_hi ? r_wd[63:32] : r_wd[31:0];
`else
  // Upper half of the shifted enable only exists to detect word-crossing accesses.
  logic [7:0] w_be8;
  assign w_be8       = {4'b0000, i_mask[3:0]} << w_off;
  assign w_be        = w_be8[3:0];
  assign w_wd        = i_st_data << {w_off, 3'b000};
  assign w_bad       = !w_size_ok || (|w_be8[7:4]);
  assign o_mem_addr  = r_addr[31:2];
  assign o_mem_be    = r_be;
  assign o_mem_wdata = r_wd;
`endif

  assign o_busy    = (r_state != IDLE) || i_req;
  assign o_done    = (r_state == DONE);
  assign o_err     = r_err;
  assign o_mem_req = (r_state == ACC1) || (r_state == ACC2);
  assign o_mem_we  = o_mem_req && r_we;

  // Load result is formed from the captured beats during DONE, then held in r_ld_data.
  assign w_ext     = extend({r_rd_hi, r_rd_lo}, r_addr[1:0], r_mask);
  assign o_ld_data = (o_done && !r_we && !r_err) ? w_ext : r_ld_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_mask    <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wd      <= '0;
      r_rd_lo   <= '0;
      r_rd_hi   <= '0;
      r_ld_data <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_req) begin
          r_addr  <= i_addr;
          r_mask  <= i_mask;
          r_we    <= i_memWrEnable;
          r_be    <= w_be;
          r_wd    <= w_wd;
          r_rd_lo <= '0;
          r_rd_hi <= '0;
          r_err   <= w_bad;
          if (w_bad) r_ld_data <= '0;
          r_state <= w_bad ? DONE : ACC1;
        end
        ACC1: if (i_mem_ack) begin
          r_rd_lo <= i_mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          r_state <= (|r_be[7:4]) ? ACC2 : DONE;
`else
          r_state <= DONE;
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC2: if (i_mem_ack) begin
          r_rd_hi <= i_mem_rdata;
          r_state <= DONE;
        end
`endif
        DONE: begin
          r_ld_data <= o_ld_data;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected memory beats and completions are queued at issue
// and checked by a memory responder and a completion monitor.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req = 1'b0;
  logic        i_memWrEnable = 1'b0;
  logic [4:0]  i_mask = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_st_data = '0;
  logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_ld_data, o_mem_wdata;
  logic [29:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;
  typedef struct {
    logic        err;
    logic [31:0] ld;
    int          lat;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  int    errors = 0;
  int    checks = 0;
  int    ack_wait = 0;
  int    wait_cnt = 0;
  logic  force_ack = 1'b0;
  int    cyc = 0;
  int    req_cyc = 0;
  logic [31:0] last_ld = '0;

  load_store_unit dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_memWrEnable(i_memWrEnable),
    .i_mask(i_mask), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_ld_data(o_ld_data),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: checks every request cycle against the head beat, acks after ack_wait cycles.
  always @(negedge clk) begin
    beat_t b;
    i_mem_ack = force_ack;
    if (o_mem_req) begin
      i_mem_ack = 1'b0;
      chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
      if (beat_q.size() != 0) begin
        b = beat_q[0];
        chk("mem_we", 32'(o_mem_we), 32'(b.we));
        chk("mem_addr", 32'(o_mem_addr), 32'(b.addr));
        chk("mem_be", 32'(o_mem_be), 32'(b.be));
        chk("mem_wdata", o_mem_wdata, b.wdata);
        if (wait_cnt >= ack_wait) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = b.rdata;
          void'(beat_q.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    done_t d;
    if (o_done) begin
      chk("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        d = done_q.pop_front();
        chk("done_err", 32'(o_err), 32'(d.err));
        chk("ld_data", o_ld_data, d.ld);
        chk("latency", 32'(cyc - req_cyc + 1), 32'(d.lat));
      end
    end
  end

  task automatic push_beat(input logic we, input logic [29:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd);
    beat_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.rdata = rd;
    beat_q.push_back(b);
  endtask

  task automatic expect_done(input logic err, input logic [31:0] ld, input int lat);
    done_t d;
    d.err = err; d.ld = ld; d.lat = lat;
    done_q.push_back(d);
    last_ld = ld;
  endtask

  task automatic issue(input logic we, input logic [4:0] m, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    i_req = 1'b1; i_memWrEnable = we; i_mask = m; i_addr = a; i_st_data = d;
    req_cyc = cyc;
    #1 chk("busy_in_req_cycle", 32'(o_busy), 32'd1);
    @(negedge clk);
    i_req = 1'b0; i_st_data = '0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_q.size() != 0 && n < 40) begin
      chk("busy_while_active", 32'(o_busy), 32'd1);
      @(negedge clk);
      #1 n++;
    end
    if (done_q.size() != 0) begin
      chk({tag, "_timeout"}, 32'(done_q.size()), 32'd0);
      done_q.delete();
      beat_q.delete();
    end
    chk({tag, "_beats_consumed"}, 32'(beat_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_ld", o_ld_data, 32'h0);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);

    // Aligned LW
    push_beat(1'b0, 30'h40, 4'b1111, 32'h0, 32'hDEADBEEF);
    expect_done(1'b0, 32'hDEADBEEF, 3);
    issue(1'b0, 5'b01111, 32'h100, 32'h0);
    wait_done("lw");

    // LB / LBU at offset 3
    push_beat(1'b0, 30'h40, 4'b1000, 32'h0, 32'h80123456);
    expect_done(1'b0, 32'hFFFFFF80, 3);
    issue(1'b0, 5'b00001, 32'h103, 32'h0);
    wait_done("lb");
    push_beat(1'b0, 30'h40, 4'b1000, 32'h0, 32'h80123456);
    expect_done(1'b0, 32'h00000080, 3);
    issue(1'b0, 5'b10001, 32'h103, 32'h0);
    wait_done("lbu");

    // SH at offset 1: single beat, load result unchanged
    push_beat(1'b1, 30'h80, 4'b0110, 32'h00ABCD00, 32'h11111111);
    expect_done(1'b0, last_ld, 3);
    issue(1'b1, 5'b00011, 32'h201, 32'h0000ABCD);
    wait_done("sh");

    // LH / LHU at offset 2
    push_beat(1'b0, 30'h80, 4'b1100, 32'h0, 32'h80017777);
    expect_done(1'b0, 32'hFFFF8001, 3);
    issue(1'b0, 5'b00011, 32'h202, 32'h0);
    wait_done("lh");
    push_beat(1'b0, 30'h80, 4'b1100, 32'h0, 32'h80017777);
    expect_done(1'b0, 32'h00008001, 3);
    issue(1'b0, 5'b10011, 32'h202, 32'h0);
    wait_done("lhu");

    // Aligned SW
    push_beat(1'b1, 30'h4, 4'b1111, 32'hCAFEF00D, 32'h0);
    expect_done(1'b0, last_ld, 3);
    issue(1'b1, 5'b01111, 32'h10, 32'hCAFEF00D);
    wait_done("sw");

    // Word-crossing accesses
`ifdef LSU_MISALIGN_SPLIT_EN
    push_beat(1'b0, 30'h40, 4'b1100, 32'h0, 32'h33221111);
    push_beat(1'b0, 30'h41, 4'b0011, 32'h0, 32'hAAAA5544);
    expect_done(1'b0, 32'h55443322, 4);
    issue(1'b0, 5'b01111, 32'h102, 32'h0);
    wait_done("lw_split");
    push_beat(1'b0, 30'h3FFFFFFF, 4'b1110, 32'h0, 32'hAABBCCDD);
    push_beat(1'b0, 30'h00000000, 4'b0001, 32'h0, 32'h11223344);
    expect_done(1'b0, 32'h44AABBCC, 4);
    issue(1'b0, 5'b01111, 32'hFFFFFFFD, 32'h0);
    wait_done("lw_wrap");
    push_beat(1'b1, 30'h80, 4'b1000, 32'h44000000, 32'h0);
    push_beat(1'b1, 30'h81, 4'b0111, 32'h00112233, 32'h0);
    expect_done(1'b0, last_ld, 4);
    issue(1'b1, 5'b01111, 32'h203, 32'h11223344);
    wait_done("sw_split");
`else
    expect_done(1'b1, 32'h0, 2);
    issue(1'b0, 5'b01111, 32'h102, 32'h0);
    wait_done("lw_split_err");
    push_beat(1'b0, 30'h40, 4'b1111, 32'h0, 32'h01020304);
    expect_done(1'b0, 32'h01020304, 3);
    issue(1'b0, 5'b01111, 32'h100, 32'h0);
    wait_done("lw_after_err");
    expect_done(1'b1, 32'h0, 2);
    issue(1'b1, 5'b01111, 32'h203, 32'h11223344);
    wait_done("sw_split_err");
`endif

    // Three wait states on the first beat
    ack_wait = 3;
    push_beat(1'b0, 30'h41, 4'b1111, 32'h0, 32'h12345678);
    expect_done(1'b0, 32'h12345678, 6);
    issue(1'b0, 5'b01111, 32'h104, 32'h0);
    wait_done("lw_wait");
    ack_wait = 0;

    // Reset while ACC1 waits for an ack that never comes
    ack_wait = 1000;
    push_beat(1'b0, 30'hC0, 4'b1111, 32'h0, 32'h0);
    issue(1'b0, 5'b01111, 32'h300, 32'h0);
    @(negedge clk);
    #1 chk("mid_mem_req", 32'(o_mem_req), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    beat_q.delete();
    done_q.delete();
    wait_cnt = 0;
    ack_wait = 0;
    last_ld = '0;
    chk("after_rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("after_rst_busy", 32'(o_busy), 32'd0);
    chk("after_rst_ld", o_ld_data, 32'h0);
    chk("after_rst_done", 32'(o_done), 32'd0);
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 chk("stale_ack_mem_req", 32'(o_mem_req), 32'd0);
      chk("stale_ack_done", 32'(o_done), 32'd0);
    end
    force_ack = 1'b0;

    // Illegal mask: no beat, error completion
    expect_done(1'b1, 32'h0, 2);
    issue(1'b0, 5'b00111, 32'h100, 32'h0);
    wait_done("bad_mask");

    // Recovery after error
    push_beat(1'b0, 30'h40, 4'b0001, 32'h0, 32'h000000FE);
    expect_done(1'b0, 32'hFFFFFFFE, 3);
    issue(1'b0, 5'b00001, 32'h100, 32'h0);
    wait_done("lb_after_err");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
